pipe_skid_buffer_2d: RTL and testbench
======================================

Name: pipe_skid_buffer_2D

Overview:
- Elastic pipeline stage for 2D array payloads (one word = ARRAY_DEPTH elements of DATAW bits) with a valid/ready handshake on both sides.
- Pairs with the enable-driven pipeline register. That register relies on an external stall enable. This block generates the upstream stall (in_ready) itself from downstream backpressure (out_ready).
- Used between router stages (e.g. VA->SA, SA->ST) where the consumer can stall.
- A 2-entry skid buffer gives full throughput (1 word/cycle), and in_ready is driven only from registered state, with no combinational path from out_ready.

Parameters:
- DATAW, 4, bit width of each array element.
- ARRAY_DEPTH, 4, number of elements per word; all elements move together as one word.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present on in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  [DATAW-1:0] x [ARRAY_DEPTH-1:0]  upstream word (unpacked array).
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  [DATAW-1:0] x [ARRAY_DEPTH-1:0]  head word (unpacked array).
- occupancy  output  2  number of held words: 0, 1 or 2.

Behaviour:
- Storage:
  - main_q is the head word; it drives out_data directly.
  - skid_q is the second word.
  - The state register is one of EMPTY, BUSY or FULL.
- Fire rules:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
- Outputs decoded from the state register only:
  - in_ready = (state != FULL) && !reset.
  - out_valid = (state != EMPTY) && !reset.
  - occupancy is EMPTY=0, BUSY=1, FULL=2.
- Reset (sync): at the clk edge with reset=1, state<=EMPTY and main_q/skid_q<=0. While reset is high, in_ready=0 and out_valid=0, so no transfers occur. In the first cycle after reset deasserts: in_ready=1, out_valid=0, out_data=all zeros, occupancy=0.
- EMPTY transitions:
  - in_fire: main_q<=in_data, go to BUSY.
  - otherwise hold.
  - out_ready is ignored.
- BUSY transitions:
  - in_fire && out_fire: main_q<=in_data, stay BUSY (streaming).
  - in_fire only: skid_q<=in_data, go to FULL.
  - out_fire only: go to EMPTY; main_q retains its stale value.
  - neither: hold.
- FULL transitions (in_ready=0, in_valid ignored):
  - out_fire: main_q<=skid_q, go to BUSY.
  - otherwise hold.
- Latency: a word accepted at edge N appears on out_data with out_valid=1 in the cycle after edge N (1 cycle), when the block is empty or draining.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- Ordering: strict FIFO. No word is dropped or duplicated.
- Stability: while out_valid && !out_ready, out_data and out_valid hold unchanged.
- Reset mid-operation: held words are discarded with no output pulse, and the block returns to the post-reset condition above.
- Upstream misuse: in_valid asserted while in_ready=0 has no effect. Upstream is required to hold the word.
- Array handling: every element index is updated together. There is no per-element enable.
- Illegal state encodings recover to EMPTY on the next edge.

Test Plan (DATAW=4, ARRAY_DEPTH=4):
- Reset: hold reset 2 cycles with in_valid=1 and in_data={F,F,F,F} -> in_ready=0 and out_valid=0 throughout. After release: occupancy=0, out_data={0,0,0,0}, in_ready=1.
- Single word: in {1,2,3,4} for 1 cycle with out_ready=1 -> next cycle out_valid=1, out_data={1,2,3,4}. Following cycle out_valid=0, occupancy=0.
- Stream: 8 back-to-back words with element values k..k+3 for k=0..7 and out_ready=1 -> out_valid=1 for 8 consecutive cycles, same order, occupancy=1 throughout, in_ready never drops.
- Backpressure fill: out_ready=0; send words A={1,1,1,1} then B={2,2,2,2} -> occupancy 1 then 2. in_ready=0 in the cycle after B is accepted. A third word C offered stays unaccepted. out_data holds A stable.
- Drain: from FULL, raise out_ready for 3 cycles with C still offered -> output order A, B, C with no gap. in_ready=1 in the cycle after A drains.
- Mid-operation reset: in FULL (A, B held), pulse reset for 1 cycle -> A and B are never output; occupancy=0 after reset; the next word D={9,9,9,9} emerges normally.

Source files
------------

// File: rtl/pipe_skid_buffer_2d.sv
// rtl/pipe_skid_buffer_2d.sv - two-entry elastic skid stage for array-word payloads
module pipe_skid_buffer_2d #(
    parameter int DATAW       = 4,
    parameter int ARRAY_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data [ARRAY_DEPTH-1:0],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data [ARRAY_DEPTH-1:0],
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [DATAW-1:0] main_q [ARRAY_DEPTH-1:0];
    logic [DATAW-1:0] skid_q [ARRAY_DEPTH-1:0];
    logic             in_fire;
    logic             out_fire;

    // Handshake outputs come only from the state register (and reset), so
    // out_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready  = (state == EMPTY || state == BUSY) && !reset;
        out_valid = (state == BUSY || state == FULL) && !reset;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        case (state)
            BUSY:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Head word drives the output directly; the whole array moves as one word.
    assign out_data = main_q;

    // State and storage update; the skid entry only fills when the head stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            for (int i = 0; i < ARRAY_DEPTH; i++) begin
                main_q[i] <= '0;
                skid_q[i] <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= BUSY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_buffer_2d.sv
// tb/tb_pipe_skid_buffer_2d.sv - self-checking bench for pipe_skid_buffer_2d
module tb_pipe_skid_buffer_2d;
    localparam int DW = 4;
    localparam int AD = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [1:0]    occupancy;
    logic [DW-1:0] in_data  [AD-1:0];
    logic [DW-1:0] out_data [AD-1:0];

    int checks = 0;
    int errors = 0;

    // behavioural model: FIFO of packed words plus the value left on the head
    logic [15:0] mq[$];
    logic [15:0] stale    = 16'h0;
    bit          model_ok = 1'b0;

    pipe_skid_buffer_2d #(.DATAW(DW), .ARRAY_DEPTH(AD)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pack_in();
        logic [15:0] w;
        for (int i = 0; i < AD; i++) w[4*i +: 4] = in_data[i];
        return w;
    endfunction

    function automatic logic [15:0] pack_out();
        logic [15:0] w;
        for (int i = 0; i < AD; i++) w[4*i +: 4] = out_data[i];
        return w;
    endfunction

    task automatic set_in(input logic [15:0] w);
        for (int i = 0; i < AD; i++) in_data[i] = w[4*i +: 4];
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // model update: what transfers the rules allow at this edge
    always @(posedge clk) begin
        int sz;
        bit inf;
        bit outf;
        sz = mq.size();
        if (reset) begin
            mq.delete();
            stale    = 16'h0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            outf = (sz > 0) && out_ready;
            inf  = in_valid && (sz < 2);
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(pack_in());
            if (mq.size() > 0) stale = mq[0];
        end
    end

    // per-cycle compare against the model, mid-cycle
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_in_ready", 32'(in_ready), 32'((mq.size() < 2) && !reset));
            chk("m_out_valid", 32'(out_valid), 32'((mq.size() > 0) && !reset));
            chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
            chk("m_out_data", 32'(pack_out()), 32'((mq.size() > 0) ? mq[0] : stale));
        end
    end

    initial begin
        logic [15:0] w;

        // reset held with upstream pushing all-ones
        set_in(16'hFFFF);
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_occ", 32'(occupancy), 32'd0);
        chk("post_rst_data", 32'(pack_out()), 32'h0000);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // single word
        tick();
        set_in(16'h1234);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(pack_out()), 32'h1234);
        tick();
        chk("single_gone_valid", 32'(out_valid), 32'd0);
        chk("single_gone_occ", 32'(occupancy), 32'd0);

        // back-to-back stream
        for (int k = 0; k < 8; k++) begin
            w = {4'(k), 4'(k + 1), 4'(k + 2), 4'(k + 3)};
            set_in(w);
            in_valid = 1'b1;
            tick();
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data", 32'(pack_out()), 32'(w));
            chk("stream_occ", 32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end_valid", 32'(out_valid), 32'd0);

        // backpressure fill
        out_ready = 1'b0;
        set_in(16'h1111);
        in_valid = 1'b1;
        tick();
        chk("fill_a_occ", 32'(occupancy), 32'd1);
        chk("fill_a_data", 32'(pack_out()), 32'h1111);
        set_in(16'h2222);
        tick();
        chk("fill_b_occ", 32'(occupancy), 32'd2);
        chk("fill_b_in_ready", 32'(in_ready), 32'd0);
        set_in(16'h3333);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("fill_c_occ", 32'(occupancy), 32'd2);
            chk("fill_c_valid", 32'(out_valid), 32'd1);
            chk("fill_c_hold", 32'(pack_out()), 32'h1111);
        end

        // drain A, B, C with C still offered
        out_ready = 1'b1;
        #1;
        chk("drain_a_data", 32'(pack_out()), 32'h1111);
        tick();
        chk("drain_b_in_ready", 32'(in_ready), 32'd1);
        chk("drain_b_valid", 32'(out_valid), 32'd1);
        chk("drain_b_data", 32'(pack_out()), 32'h2222);
        tick();
        in_valid = 1'b0;
        chk("drain_c_valid", 32'(out_valid), 32'd1);
        chk("drain_c_data", 32'(pack_out()), 32'h3333);
        tick();
        chk("drain_end_valid", 32'(out_valid), 32'd0);
        chk("drain_end_occ", 32'(occupancy), 32'd0);

        // mid-operation reset from FULL
        out_ready = 1'b0;
        set_in(16'hAAAA);
        in_valid = 1'b1;
        tick();
        set_in(16'hBBBB);
        tick();
        chk("mid_full_occ", 32'(occupancy), 32'd2);
        reset    = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_post_occ", 32'(occupancy), 32'd0);
        chk("mid_post_valid", 32'(out_valid), 32'd0);
        chk("mid_post_data", 32'(pack_out()), 32'h0000);
        set_in(16'h9999);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid_d_valid", 32'(out_valid), 32'd1);
        chk("mid_d_data", 32'(pack_out()), 32'h9999);
        tick();
        chk("mid_d_gone_occ", 32'(occupancy), 32'd0);

        // randomized traffic, checked by the per-cycle model compare
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (n % 500 >= 400) out_ready = ($urandom_range(0, 4) == 0);
            set_in(16'($urandom));
            tick();
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
